// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller and its event FIFO.
package key_scan_pkg;

  localparam logic [3:0]  ROW_IDLE = 4'b1111;
  localparam int unsigned CODE_W   = 4;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_e;

  typedef struct packed {
    res_kind_e         kind;
    logic [CODE_W-1:0] code;
  } frame_res_t;

  localparam frame_res_t RES_IDLE = '{kind: RES_NONE, code: '0};

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_e;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Code is forced to zero for NONE/MULTI so results compare cleanly frame to frame.
  function automatic frame_res_t classify_row(input logic [1:0] row, input logic [3:0] col);
    frame_res_t  r;
    int unsigned zeros;
    r     = RES_IDLE;
    zeros = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col[i]) begin
        zeros++;
        r.code = {row, 2'(i)};
      end
    end
    if (zeros == 1) begin
      r.kind = RES_KEY;
    end else if (zeros > 1) begin
      r.kind = RES_MULTI;
      r.code = '0;
    end
    return r;
  endfunction

  function automatic frame_res_t merge_res(input frame_res_t acc, input frame_res_t row);
    frame_res_t r;
    if (acc.kind == RES_NONE) begin
      r = row;
    end else if (row.kind == RES_NONE) begin
      r = acc;
    end else begin
      r = '{kind: RES_MULTI, code: '0};
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small show-ahead event FIFO; a push is accepted when full only if a pop happens in the same cycle.
module key_event_fifo
  import key_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      push_i,
  input  logic [CODE_W-1:0]         data_i,
  input  logic                      pop_i,
  output logic [CODE_W-1:0]         data_o,
  output logic                      valid_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q;
  logic              pop_ok, push_ok;

  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    pop_ok  = pop_i && valid_q;
    push_ok = push_i && (!full_o || pop_ok);
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign data_o  = valid_q ? mem_q[rd_q] : '0;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/key_scan_ctrl.sv
// Autonomous 4x4 keypad scanner: row sequencing, column sampling, frame-level debounce
// and one FIFO event per debounced press.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          enable,
  input  logic [3:0]                    COL,
  output logic [3:0]                    ROW,
  input  logic                          pop,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          irq
);

  localparam int unsigned     DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      STABLE_MAX = 4'(DEBOUNCE_SCANS);

  logic [3:0]       col_meta_q, col_sync_q;
  scan_state_e      state_q;
  logic [1:0]       row_idx_q;
  logic [DIV_W-1:0] dwell_q;
  logic [3:0]       row_q;
  frame_res_t       frame_q, prev_q;
  logic [3:0]       stable_q;
  logic             armed_q;
  logic             overflow_q;

  frame_res_t       row_res, frame_d;
  logic             frame_end, accept, drop;
  logic [3:0]       stable_d;
  logic             fifo_valid, fifo_full;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= COL;
      col_sync_q <= col_meta_q;
    end
  end

  // frame_d/stable_d are only meaningful on the last dwell cycle of row 3.
  always_comb begin
    row_res   = classify_row(row_idx_q, col_sync_q);
    frame_d   = merge_res(frame_q, row_res);
    frame_end = (state_q == ST_SCAN) && enable && (dwell_q == DWELL_LAST) && (row_idx_q == 2'd3);
    if (frame_d == prev_q) begin
      stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1;
    end else begin
      stable_d = 4'd1;
    end
    accept = frame_end && (stable_d == STABLE_MAX) && (frame_d.kind == RES_KEY) && armed_q;
    drop   = accept && fifo_full && !(pop && fifo_valid);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      row_idx_q <= '0;
      dwell_q   <= '0;
      row_q     <= ROW_IDLE;
      frame_q   <= RES_IDLE;
      prev_q    <= RES_IDLE;
      stable_q  <= '0;
      armed_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          row_q <= ROW_IDLE;
          if (enable) begin
            state_q   <= ST_SCAN;
            row_idx_q <= '0;
            dwell_q   <= '0;
            row_q     <= row_drive(2'd0);
            frame_q   <= RES_IDLE;
          end
        end
        ST_SCAN: begin
          if (!enable) begin
            state_q   <= ST_IDLE;
            row_q     <= ROW_IDLE;
            row_idx_q <= '0;
            dwell_q   <= '0;
            frame_q   <= RES_IDLE;
            prev_q    <= RES_IDLE;
            stable_q  <= '0;
            armed_q   <= 1'b1;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_q   <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_q     <= row_drive(row_idx_q + 2'd1);
            if (row_idx_q == 2'd3) begin
              frame_q  <= RES_IDLE;
              prev_q   <= frame_d;
              stable_q <= stable_d;
              if (accept) begin
                armed_q <= 1'b0;
              end else if ((stable_d == STABLE_MAX) && (frame_d.kind == RES_NONE)) begin
                armed_q <= 1'b1;
              end
            end else begin
              frame_q <= frame_d;
            end
          end else begin
            dwell_q <= dwell_q + DIV_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push_i  (accept),
    .data_i  (frame_d.code),
    .pop_i   (pop),
    .data_o  (key_code),
    .valid_o (fifo_valid),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  // irq comes straight from the FIFO's registered non-empty flag.
  assign ROW       = row_q;
  assign key_valid = fifo_valid;
  assign irq       = fifo_valid;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: directed frame table, randomized frames against a
// frame-level reference model, plus reset and enable-drop sequences.
module tb_key_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       enable;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic       pop;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;
  logic       irq;

  logic [15:0] keys_down;

  int errors = 0;
  int checks = 0;

  // reference model state, frame-level
  int m_q[$];
  int m_prev;
  int m_stable;
  bit m_armed;
  bit m_ovf;

  typedef struct {
    int          reps;
    logic [15:0] keys;
    int          pop_cyc;
    int          clr_cyc;
    int          cnt;
    int          code;
    int          ovf;
  } vec_t;

  always #5 HCLK = ~HCLK;

  // a held key connects its row line to its column line
  always_comb begin
    COL = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!ROW[r] && keys_down[r*4+c]) COL[c] = 1'b0;
  end

  key_scan_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .enable     (enable),
    .COL        (COL),
    .ROW        (ROW),
    .pop        (pop),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .irq        (irq)
  );

  function automatic logic [15:0] K(input int c);
    return 16'(1) << c;
  endfunction

  function automatic vec_t V(input int reps, input logic [15:0] keys, input int pop_cyc,
                             input int clr, input int cnt, input int code, input int ovf);
    vec_t v;
    v.reps = reps; v.keys = keys; v.pop_cyc = pop_cyc; v.clr_cyc = clr ? 8 : -1;
    v.cnt = cnt; v.code = code; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input int cnt, input int code, input int ovf);
    check("fifo_count", int'(fifo_count), cnt);
    check("key_valid", int'(key_valid), (cnt != 0) ? 1 : 0);
    check("irq", int'(irq), (cnt != 0) ? 1 : 0);
    check("key_code", int'(key_code), (cnt != 0) ? code : 0);
    check("overflow", int'(overflow), ovf);
  endtask

  task automatic check_model();
    check_out(m_q.size(), (m_q.size() > 0) ? m_q[0] : 0, int'(m_ovf));
  endtask

  task automatic check_reset_vals();
    check("rst_row", int'(ROW), 15);
    check_out(0, 0, 0);
  endtask

  function automatic int frame_of(input logic [15:0] k);
    int code;
    code = -1;
    if ($countones(k) > 1) return -2;
    for (int i = 0; i < 16; i++) if (k[i]) code = i;
    return code;
  endfunction

  function automatic void m_debounce_clear();
    m_prev = -1; m_stable = 0; m_armed = 1'b1;
  endfunction

  function automatic void m_reset();
    m_q.delete(); m_ovf = 1'b0;
    m_debounce_clear();
  endfunction

  function automatic void m_frame_end(input int fr);
    if (fr == m_prev) begin
      if (m_stable < DEB) m_stable++;
    end else begin
      m_prev = fr; m_stable = 1;
    end
    if (m_stable == DEB) begin
      if (fr >= 0 && m_armed) begin
        if (m_q.size() < DEPTH) m_q.push_back(fr);
        else m_ovf = 1'b1;
        m_armed = 1'b0;
      end else if (fr == -1) begin
        m_armed = 1'b1;
      end
    end
  endfunction

  // called at the first cycle of a frame; returns at the first cycle of the next frame
  task automatic run_frame(input logic [15:0] keys, input int pop_cyc, input int clr_cyc);
    keys_down = keys;
    for (int c = 0; c < FRAME; c++) begin
      pop     = (c == pop_cyc);
      ovf_clr = (c == clr_cyc);
      @(negedge HCLK);
    end
    pop = 1'b0; ovf_clr = 1'b0;
    if (pop_cyc >= 0 && m_q.size() > 0) void'(m_q.pop_front());
    if (clr_cyc >= 0) m_ovf = 1'b0;
    m_frame_end(frame_of(keys));
    check("row_frame_start", int'(ROW), 14);
  endtask

  task automatic align();
    logic [3:0] prev;
    bit found;
    prev = ROW; found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge HCLK);
      if (ROW == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = ROW;
    end
    check("align", int'(found), 1);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [3:0]  exp_row;
    logic [15:0] cur;
    int          pop_c, clr_c, sel, a, b;

    // directed frame table: expectations after each frame, starting from a fresh reset
    tbl.push_back(V(1,  K(9), -1, 0, 0, 0, 0));
    tbl.push_back(V(1,  K(9), -1, 0, 1, 9, 0));
    tbl.push_back(V(10, K(9), -1, 0, 1, 9, 0));
    tbl.push_back(V(2,  '0,   -1, 0, 1, 9, 0));
    tbl.push_back(V(1,  K(9), -1, 0, 1, 9, 0));
    tbl.push_back(V(1,  K(9), -1, 0, 2, 9, 0));
    tbl.push_back(V(1,  '0,    4, 0, 1, 9, 0));
    tbl.push_back(V(1,  '0,    4, 0, 0, 0, 0));
    tbl.push_back(V(6,  K(0) | K(5), -1, 0, 0, 0, 0));
    tbl.push_back(V(2,  '0,   -1, 0, 0, 0, 0));
    tbl.push_back(V(1,  K(3), -1, 0, 0, 0, 0));
    tbl.push_back(V(1,  K(3), -1, 0, 1, 3, 0));
    tbl.push_back(V(1,  '0,    4, 0, 0, 0, 0));
    tbl.push_back(V(1,  '0,   -1, 0, 0, 0, 0));
    for (int c = 1; c <= 5; c++) begin
      int held, after;
      held  = (c - 1 < DEPTH) ? c - 1 : DEPTH;
      after = (c < DEPTH) ? c : DEPTH;
      tbl.push_back(V(1, K(c), -1, 0, held,  (held > 0) ? 1 : 0, 0));
      tbl.push_back(V(1, K(c), -1, 0, after, 1, (c == 5) ? 1 : 0));
      tbl.push_back(V(2, '0,   -1, 0, after, 1, (c == 5) ? 1 : 0));
    end
    for (int p = 1; p <= 4; p++)
      tbl.push_back(V(1, '0, 4, 0, 4 - p, (p < 4) ? p + 1 : 0, 1));
    tbl.push_back(V(1, '0, -1, 1, 0, 0, 0));
    for (int c = 1; c <= 4; c++) begin
      tbl.push_back(V(1, K(c), -1, 0, c - 1, (c > 1) ? 1 : 0, 0));
      tbl.push_back(V(1, K(c), -1, 0, c, 1, 0));
      tbl.push_back(V(2, '0,   -1, 0, c, 1, 0));
    end
    tbl.push_back(V(1, K(7), -1, 0, 4, 1, 0));
    tbl.push_back(V(1, K(7), 15, 0, 4, 2, 0));
    tbl.push_back(V(1, '0,    4, 0, 3, 3, 0));
    tbl.push_back(V(1, '0,    4, 0, 2, 4, 0));
    tbl.push_back(V(1, '0,    4, 0, 1, 7, 0));
    tbl.push_back(V(1, '0,    4, 0, 0, 0, 0));

    HRESETn = 1'b0; enable = 1'b0; pop = 1'b0; ovf_clr = 1'b0; keys_down = '0;
    m_reset();
    repeat (3) @(negedge HCLK);
    check_reset_vals();
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);
    check("idle_row", int'(ROW), 15);

    enable = 1'b1;
    align();
    for (int i = 0; i < 2 * FRAME; i++) begin
      exp_row = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check("row_seq", int'(ROW), int'(exp_row));
      @(negedge HCLK);
    end
    m_frame_end(-1);
    m_frame_end(-1);

    foreach (tbl[t]) begin
      for (int r = 0; r < tbl[t].reps; r++) begin
        run_frame(tbl[t].keys, tbl[t].pop_cyc, tbl[t].clr_cyc);
        check_out(tbl[t].cnt, tbl[t].code, tbl[t].ovf);
      end
    end

    // reset in the middle of a row dwell
    repeat (5) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check_reset_vals();
    keys_down = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    m_reset();
    align();

    cur = '0;
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 9) >= 6) begin
        sel = $urandom_range(0, 9);
        if (sel < 4) cur = '0;
        else if (sel < 9) cur = K($urandom_range(0, 15));
        else begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          cur = K(a) | K(b);
        end
      end
      pop_c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, FRAME - 1) : -1;
      clr_c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, FRAME - 1) : -1;
      run_frame(cur, pop_c, clr_c);
      check_model();
    end

    // enable drop with events queued
    for (int i = 0; i < 4; i++) begin
      run_frame('0, 4, (i == 0) ? 8 : -1);
      check_model();
    end
    run_frame(K(10), -1, -1); check_model();
    run_frame(K(10), -1, -1); check_model();
    run_frame('0, -1, -1);    check_model();
    run_frame('0, -1, -1);    check_model();
    run_frame(K(11), -1, -1); check_model();
    run_frame(K(11), -1, -1); check_model();
    run_frame('0, -1, -1);    check_model();
    run_frame('0, -1, -1);    check_model();
    run_frame(K(6), -1, -1);  check_model();
    keys_down = K(6);
    repeat (6) @(negedge HCLK);
    enable = 1'b0;
    @(negedge HCLK);
    check("drop_row", int'(ROW), 15);
    m_debounce_clear();
    repeat (20) @(negedge HCLK);
    check("drop_row_hold", int'(ROW), 15);
    check_model();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_q.size() > 0) begin
        check("drain_code", int'(key_code), m_q[0]);
        pop = 1'b1;
        @(negedge HCLK);
        pop = 1'b0;
        void'(m_q.pop_front());
        check_model();
      end
    end
    enable = 1'b1;
    align();
    run_frame(K(6), -1, -1); check_model();
    run_frame(K(6), -1, -1); check_model();

    // reset with a non-empty FIFO
    repeat (7) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check_reset_vals();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
